// File: rtl/decryption_word_loader_pkg.sv
// Shared types and sizes for the AES-128 decryption word loader.
// The loader moves 32-bit words in and out of 128-bit blocks, most significant word first.
package decryption_word_loader_pkg;

    localparam int WORDS_PER_BLOCK = 4;
    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = 128;

    typedef enum logic [1:0] {
        LOAD,
        START,
        WAIT,
        DRAIN
    } state_e;

    // The newest word always enters at the least significant end.
    function automatic logic [BLOCK_W-1:0] shiftInWord(input logic [BLOCK_W-1:0] blk,
                                                       input logic [WORD_W-1:0]  word);
        return {blk[BLOCK_W-WORD_W-1:0], word};
    endfunction

    function automatic logic [WORD_W-1:0] topWord(input logic [BLOCK_W-1:0] blk);
        return blk[BLOCK_W-1 -: WORD_W];
    endfunction

endpackage

// File: rtl/decryption_word_loader_if.sv
// Stream, core and status signals of the decryption word loader.
// The slave modport is the loader's view; master is the surrounding system's view.
interface decryption_word_loader_if;
    import decryption_word_loader_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [WORD_W-1:0]    in_data;
    logic                 in_key;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_W-1:0]    out_data;
    logic                 out_last;
    logic                 core_start;
    logic [BLOCK_W-1:0]   core_key;
    logic [BLOCK_W-1:0]   core_ciphertext;
    logic [BLOCK_W-1:0]   core_plaintext;
    logic                 core_done;
    logic                 key_loaded;
    logic                 busy;
    logic                 err_no_key;
    logic                 err_timeout;
    logic                 clear_err;

    modport slave (
        input  in_valid, in_data, in_key, out_ready, core_plaintext, core_done, clear_err,
        output in_ready, out_valid, out_data, out_last, core_start, core_key,
               core_ciphertext, key_loaded, busy, err_no_key, err_timeout
    );

    modport master (
        output in_valid, in_data, in_key, out_ready, core_plaintext, core_done, clear_err,
        input  in_ready, out_valid, out_data, out_last, core_start, core_key,
               core_ciphertext, key_loaded, busy, err_no_key, err_timeout
    );

endinterface

// File: rtl/decryption_word_loader_word_shift_reg.sv
// 128-bit register that shifts left one 32-bit word at a time, with parallel load and clear.
// Clear has priority over load, and load over shift.
module decryption_word_loader_word_shift_reg
    import decryption_word_loader_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               load_i,
    input  logic [BLOCK_W-1:0] loadData_i,
    input  logic               shift_i,
    input  logic [WORD_W-1:0]  shiftData_i,
    output logic [BLOCK_W-1:0] data_o
);

    logic [BLOCK_W-1:0] data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (clear_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= loadData_i;
        end else if (shift_i) begin
            data_q <= shiftInWord(data_q, shiftData_i);
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/decryption_word_loader.sv
// Collects key/ciphertext words for an AES-128 decryption core, starts it, and streams the
// plaintext back out; the key is kept so many blocks can be decrypted under one key load.
module decryption_word_loader
    import decryption_word_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
)
(
    input  logic                     clk,
    input  logic                     reset,
    decryption_word_loader_if.slave  bus
);

    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TO_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q;
    logic [1:0]         wordCnt_q;
    logic [TO_W-1:0]    waitCnt_q;
    logic               groupKey_q;
    logic               coreStart_q;
    logic               outValid_q;
    logic               outLast_q;
    logic               keyLoaded_q;
    logic               errNoKey_q;
    logic               errTimeout_q;
    logic [BLOCK_W-1:0] coreKey_q;
    logic [BLOCK_W-1:0] coreCt_q;

    logic               inAccept;
    logic               outAccept;
    logic               restart;
    logic               groupDone;
    logic               captureDone;
    logic [BLOCK_W-1:0] stageBlk;
    logic [BLOCK_W-1:0] outBlk;
    logic [BLOCK_W-1:0] groupData_d;

    assign inAccept    = bus.in_valid && (state_q == LOAD);
    assign outAccept   = outValid_q && bus.out_ready;
    assign restart     = inAccept && (wordCnt_q != 2'd0) && (bus.in_key != groupKey_q);
    assign groupDone   = inAccept && !restart && (wordCnt_q == 2'd3);
    assign captureDone = (state_q == WAIT) && bus.core_done;
    assign groupData_d = shiftInWord(stageBlk, bus.in_data);

    // Staging is wiped once a group completes so key material does not linger there.
    decryption_word_loader_word_shift_reg u_stage (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (groupDone),
        .load_i      (1'b0),
        .loadData_i  ('0),
        .shift_i     (inAccept),
        .shiftData_i (bus.in_data),
        .data_o      (stageBlk)
    );

    decryption_word_loader_word_shift_reg u_drain (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (1'b0),
        .load_i      (captureDone),
        .loadData_i  (bus.core_plaintext),
        .shift_i     (outAccept),
        .shiftData_i ('0),
        .data_o      (outBlk)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= LOAD;
            wordCnt_q    <= '0;
            waitCnt_q    <= '0;
            groupKey_q   <= 1'b0;
            coreStart_q  <= 1'b0;
            outValid_q   <= 1'b0;
            outLast_q    <= 1'b0;
            keyLoaded_q  <= 1'b0;
            errNoKey_q   <= 1'b0;
            errTimeout_q <= 1'b0;
            coreKey_q    <= '0;
            coreCt_q     <= '0;
        end else begin
            coreStart_q  <= 1'b0;
            // A new error event later in this block overrides a same-cycle clear.
            errNoKey_q   <= errNoKey_q & ~bus.clear_err;
            errTimeout_q <= errTimeout_q & ~bus.clear_err;
            case (state_q)
                LOAD: begin
                    if (restart) begin
                        groupKey_q <= bus.in_key;
                        wordCnt_q  <= 2'd1;
                    end else if (inAccept) begin
                        wordCnt_q <= wordCnt_q + 2'd1;
                        if (wordCnt_q == 2'd0) begin
                            groupKey_q <= bus.in_key;
                        end
                        if (groupDone) begin
                            if (groupKey_q) begin
                                coreKey_q   <= groupData_d;
                                keyLoaded_q <= 1'b1;
                            end else if (keyLoaded_q) begin
                                coreCt_q    <= groupData_d;
                                coreStart_q <= 1'b1;
                                state_q     <= START;
                            end else begin
                                errNoKey_q  <= 1'b1;
                            end
                        end
                    end
                end
                START: begin
                    waitCnt_q <= '0;
                    state_q   <= WAIT;
                end
                WAIT: begin
                    if (bus.core_done) begin
                        outValid_q <= 1'b1;
                        outLast_q  <= 1'b0;
                        state_q    <= DRAIN;
                    end else if ((TIMEOUT_CYCLES != 0) && (waitCnt_q == TO_LAST)) begin
                        errTimeout_q <= 1'b1;
                        state_q      <= LOAD;
                    end else begin
                        waitCnt_q <= waitCnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (outAccept) begin
                        wordCnt_q <= wordCnt_q + 2'd1;
                        if (wordCnt_q == 2'd3) begin
                            outValid_q <= 1'b0;
                            outLast_q  <= 1'b0;
                            state_q    <= LOAD;
                        end else begin
                            outLast_q  <= (wordCnt_q == 2'd2);
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign bus.in_ready        = (state_q == LOAD);
    assign bus.busy            = (state_q != LOAD);
    assign bus.out_valid       = outValid_q;
    assign bus.out_last        = outLast_q;
    assign bus.out_data        = topWord(outBlk);
    assign bus.core_start      = coreStart_q;
    assign bus.core_key        = coreKey_q;
    assign bus.core_ciphertext = coreCt_q;
    assign bus.key_loaded      = keyLoaded_q;
    assign bus.err_no_key      = errNoKey_q;
    assign bus.err_timeout     = errTimeout_q;

endmodule

// File: tb/tb_decryption_word_loader.sv
// Scoreboard bench for decryption_word_loader: directed blocks go in, a lookup-table core
// model answers start pulses, and a monitor checks every output beat against a queue.
module tb_decryption_word_loader;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   startCount = 0;
    int   startCycle = 0;
    int   beatCount = 0;
    int   readyMode = 0;
    bit   coreEnable = 1'b1;
    bit   stalled = 1'b0;

    beat_t        expQ[$];
    logic [127:0] ctQ[$];
    logic [127:0] ptQ[$];
    logic [127:0] expKey = '0;
    logic [127:0] modelCt;
    logic [127:0] modelPt;
    logic [31:0]  heldData;
    beat_t        monB;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_B     = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] PT_B     = 128'hdeadbeef0123456789abcdefcafef00d;
    localparam logic [127:0] CT_C     = 128'h11111111222222223333333344444444;
    localparam logic [127:0] PT_C     = 128'ha5a5a5a55a5a5a5ac3c3c3c33c3c3c3c;
    localparam logic [127:0] CT_D     = 128'hfedcba9876543210fedcba9876543210;
    localparam logic [127:0] PT_D     = 128'h0badf00d8badf00d7badf00d6badf00d;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    decryption_word_loader_if dutIf ();

    decryption_word_loader #(
        .TIMEOUT_CYCLES (20),
        .TO_W           (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dutIf)
    );

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name, input string detail);
        checks++;
        failures++;
        $display("[TB] FAIL %s: %s", name, detail);
    endtask

    task automatic syncPos();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the word was accepted.
    task automatic applyStimulus(input logic [31:0] word, input logic isKey);
        int n;
        n = 0;
        dutIf.in_valid = 1'b1;
        dutIf.in_data  = word;
        dutIf.in_key   = isKey;
        @(negedge clk);
        while (!dutIf.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!dutIf.in_ready) reportFail("in_ready_wait", "got in_ready low for 200 cycles, want high");
        @(posedge clk);
        #1;
        dutIf.in_valid = 1'b0;
    endtask

    task automatic applyBlock(input logic [127:0] blk, input logic isKey);
        for (int i = 0; i < 4; i++) applyStimulus(blk[127 - 32*i -: 32], isKey);
    endtask

    task automatic pushBlock(input logic [127:0] ct, input logic [127:0] pt, input bit withBeats);
        beat_t b;
        ctQ.push_back(ct);
        ptQ.push_back(pt);
        if (withBeats) begin
            for (int i = 0; i < 4; i++) begin
                b.data = pt[127 - 32*i -: 32];
                b.last = (i == 3);
                expQ.push_back(b);
            end
        end
    endtask

    task automatic waitDrained();
        int n;
        n = 0;
        @(negedge clk);
        while (!(expQ.size() == 0 && dutIf.in_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!(expQ.size() == 0 && dutIf.in_ready))
            reportFail("drain_wait", $sformatf("got %0d beats outstanding, want 0", expQ.size()));
        syncPos();
    endtask

    always @(posedge clk) begin
        #1;
        if (readyMode == 2) dutIf.out_ready = 1'($urandom_range(0, 1));
        else                dutIf.out_ready = (readyMode == 1);
    end

    // Output monitor: pops the scoreboard on every handshake and checks stall stability.
    always @(negedge clk) begin
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checkOutput("stall_valid_hold", dutIf.out_valid, 1'b1);
                checkOutput("stall_data_hold", dutIf.out_data, heldData);
            end
            if (dutIf.out_valid) checkOutput("in_ready_while_draining", dutIf.in_ready, 1'b0);
            if (dutIf.out_valid && dutIf.out_ready) begin
                beatCount++;
                if (expQ.size() == 0) begin
                    reportFail("unexpected_beat", $sformatf("got beat %0h, want none", dutIf.out_data));
                end else begin
                    monB = expQ.pop_front();
                    checkOutput("beat_data", dutIf.out_data, monB.data);
                    checkOutput("beat_last", dutIf.out_last, monB.last);
                end
                stalled = 1'b0;
            end else if (dutIf.out_valid) begin
                stalled  = 1'b1;
                heldData = dutIf.out_data;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    // Core model: looks up the plaintext for each start and answers 12 cycles later.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && dutIf.core_start) begin
                startCount++;
                startCycle = cyc;
                modelPt = '0;
                if (coreEnable) begin
                    if (ctQ.size() == 0) begin
                        reportFail("unexpected_start", "got core_start, want none");
                    end else begin
                        modelCt = ctQ.pop_front();
                        modelPt = ptQ.pop_front();
                        checkOutput("core_ciphertext", dutIf.core_ciphertext, modelCt);
                        checkOutput("core_key_at_start", dutIf.core_key, expKey);
                    end
                end
                @(negedge clk);
                checkOutput("start_pulse_width", dutIf.core_start, 1'b0);
                if (coreEnable) begin
                    repeat (11) @(posedge clk);
                    #1;
                    dutIf.core_done      = 1'b1;
                    dutIf.core_plaintext = modelPt;
                    @(posedge clk);
                    #1;
                    dutIf.core_done = 1'b0;
                    @(negedge clk);
                    checkOutput("done_to_valid", dutIf.out_valid, 1'b1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish after 200000 time units, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int base;
        int bc;
        dutIf.in_valid       = 1'b0;
        dutIf.in_data        = '0;
        dutIf.in_key         = 1'b0;
        dutIf.out_ready      = 1'b0;
        dutIf.core_plaintext = '0;
        dutIf.core_done      = 1'b0;
        dutIf.clear_err      = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready", dutIf.in_ready, 1'b1);
        checkOutput("reset_out_valid", dutIf.out_valid, 1'b0);
        checkOutput("reset_out_last", dutIf.out_last, 1'b0);
        checkOutput("reset_out_data", dutIf.out_data, 32'h0);
        checkOutput("reset_core_start", dutIf.core_start, 1'b0);
        checkOutput("reset_core_key", dutIf.core_key, 128'h0);
        checkOutput("reset_core_ct", dutIf.core_ciphertext, 128'h0);
        checkOutput("reset_key_loaded", dutIf.key_loaded, 1'b0);
        checkOutput("reset_errors", {dutIf.err_no_key, dutIf.err_timeout}, 2'b00);
        checkOutput("reset_busy", dutIf.busy, 1'b0);
        syncPos();
        reset = 1'b0;

        $display("[TB] ciphertext without a key");
        applyBlock(FIPS_CT, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("no_key_err", dutIf.err_no_key, 1'b1);
        checkOutput("no_key_starts", startCount, 0);
        checkOutput("no_key_busy", dutIf.busy, 1'b0);
        syncPos();
        dutIf.clear_err = 1'b1;
        syncPos();
        dutIf.clear_err = 1'b0;
        @(negedge clk);
        checkOutput("no_key_cleared", dutIf.err_no_key, 1'b0);
        syncPos();

        $display("[TB] FIPS-197 vector");
        applyBlock(FIPS_KEY, 1'b1);
        expKey = FIPS_KEY;
        @(negedge clk);
        checkOutput("fips_core_key", dutIf.core_key, FIPS_KEY);
        checkOutput("fips_key_loaded", dutIf.key_loaded, 1'b1);
        syncPos();
        readyMode = 1;
        pushBlock(FIPS_CT, FIPS_PT, 1'b1);
        applyBlock(FIPS_CT, 1'b0);
        @(negedge clk);
        checkOutput("start_latency", dutIf.core_start, 1'b1);
        n = 0;
        while (!dutIf.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!dutIf.out_valid) reportFail("fips_out_valid_wait", "got out_valid low for 100 cycles, want high");
        repeat (4) @(negedge clk);
        checkOutput("fips_back_to_load", dutIf.in_ready, 1'b1);
        checkOutput("fips_valid_dropped", dutIf.out_valid, 1'b0);
        checkOutput("fips_start_count", startCount, 1);
        checkOutput("fips_scoreboard", expQ.size(), 0);
        syncPos();

        $display("[TB] random output backpressure");
        bc = beatCount;
        readyMode = 2;
        pushBlock(CT_B, PT_B, 1'b1);
        applyBlock(CT_B, 1'b0);
        waitDrained();
        checkOutput("bp_beat_count", beatCount - bc, 4);
        readyMode = 1;

        $display("[TB] key reuse over three blocks");
        base = startCount;
        bc = beatCount;
        pushBlock(CT_C, PT_C, 1'b1);
        applyBlock(CT_C, 1'b0);
        pushBlock(CT_D, PT_D, 1'b1);
        applyBlock(CT_D, 1'b0);
        pushBlock(FIPS_CT, FIPS_PT, 1'b1);
        applyBlock(FIPS_CT, 1'b0);
        waitDrained();
        checkOutput("reuse_starts", startCount - base, 3);
        checkOutput("reuse_beats", beatCount - bc, 12);
        checkOutput("reuse_core_key", dutIf.core_key, FIPS_KEY);

        $display("[TB] group type switch");
        applyStimulus(32'hffffffff, 1'b1);
        applyStimulus(32'heeeeeeee, 1'b1);
        pushBlock(CT_B, PT_B, 1'b1);
        applyBlock(CT_B, 1'b0);
        waitDrained();
        checkOutput("switch_core_key", dutIf.core_key, FIPS_KEY);
        checkOutput("switch_key_loaded", dutIf.key_loaded, 1'b1);

        $display("[TB] core never answers");
        coreEnable = 1'b0;
        applyBlock(CT_C, 1'b0);
        n = 0;
        @(negedge clk);
        while (!dutIf.err_timeout && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeout_cycle", cyc - startCycle, 21);
        checkOutput("timeout_in_ready", dutIf.in_ready, 1'b1);
        checkOutput("timeout_no_valid", dutIf.out_valid, 1'b0);
        syncPos();
        dutIf.clear_err = 1'b1;
        syncPos();
        dutIf.clear_err = 1'b0;
        @(negedge clk);
        checkOutput("timeout_cleared", dutIf.err_timeout, 1'b0);
        coreEnable = 1'b1;
        syncPos();

        $display("[TB] reset during drain");
        readyMode = 0;
        pushBlock(CT_D, PT_D, 1'b0);
        applyBlock(CT_D, 1'b0);
        n = 0;
        @(negedge clk);
        while (!dutIf.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_reached", dutIf.out_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_out_valid", dutIf.out_valid, 1'b0);
        checkOutput("async_key_loaded", dutIf.key_loaded, 1'b0);
        checkOutput("async_core_key", dutIf.core_key, 128'h0);
        @(negedge clk);
        syncPos();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_in_ready", dutIf.in_ready, 1'b1);
        checkOutput("scoreboard_empty", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decryption_word_loader.md
Name: decryption_word_loader

Overview:
- Upstream/downstream adapter for the AES-128 decryption core.
- Collects 32-bit words from a valid/ready input stream into a 128-bit key and a 128-bit ciphertext block.
- Pulses start to the core, waits for its done, then streams the 128-bit plaintext back out as four 32-bit words.
- Holds the key between blocks so that many ciphertext blocks can be decrypted under a single key load.

Parameters:
- TIMEOUT_CYCLES, 255, maximum cycles to wait in WAIT for core_done; 0 disables the timeout.
- TO_W, 8, width of the wait counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid & in_ready
- in_data  in  32  input word; first word of a group = bits [127:96]
- in_key  in  1  1 = word belongs to the key group, 0 = ciphertext group
- out_valid  out  1  plaintext word valid
- out_ready  in  1  downstream accepts the word
- out_data  out  32  plaintext word, [127:96] first
- out_last  out  1  high with the 4th word of a block
- core_start  out  1  one-cycle start pulse to the decryption core
- core_key  out  128  key to the core
- core_ciphertext  out  128  ciphertext to the core
- core_plaintext  in  128  core result
- core_done  in  1  core result valid
- key_loaded  out  1  a complete key has been received
- busy  out  1  state != LOAD
- err_no_key  out  1  sticky: ciphertext block received while key_loaded=0
- err_timeout  out  1  sticky: WAIT exceeded TIMEOUT_CYCLES
- clear_err  in  1  synchronous clear of both sticky error flags

Behaviour:
- Reset (async, active-high) values:
  - state = LOAD, word counter = 0, wait counter = 0.
  - core_start = 0, out_valid = 0, out_last = 0, out_data = 0.
  - core_key = 0, core_ciphertext = 0, key_loaded = 0, error flags = 0.
  - in_ready = 1 once reset deasserts.
- Reset asserted mid-operation aborts everything: partial groups are lost and any block being drained is lost.
- in_ready = (state == LOAD); it never depends on in_data or in_key.
- LOAD state:
  - Each accepted word shifts into a 128-bit staging register (new word enters at [31:0]); the 2-bit word counter increments.
  - The group type is latched from in_key on word 0.
  - If in_key differs from the latched type on words 1–3, the partial group is discarded and the current word becomes word 0 of a new group.
  - Key group complete (4th word accepted): core_key <= staging, key_loaded <= 1, stay in LOAD. The core key only changes here, so it is never modified while busy.
  - Ciphertext group complete with key_loaded = 1: core_ciphertext <= staging, go to START.
  - Ciphertext group complete with key_loaded = 0: block dropped, err_no_key <= 1, stay in LOAD.
- START state:
  - core_start = 1 for exactly one cycle, i.e. the cycle after the 4th ciphertext word is accepted.
  - Wait counter <= 0, go to WAIT.
- WAIT state:
  - On the first cycle with core_done = 1: capture core_plaintext into the output register, go to DRAIN. core_done seen in any other state is ignored.
  - Otherwise the wait counter increments.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES: err_timeout <= 1, return to LOAD, no output is produced.
- DRAIN state:
  - out_valid = 1; out_data = output register [127:96].
  - On each out_valid & out_ready, shift left by 32 and increment the word counter.
  - out_last = 1 while presenting word 3.
  - Handshake on word 3: out_valid <= 0, go to LOAD; in_ready is high the next cycle.
  - out_data/out_valid stay stable while out_ready = 0 (no drop, no repeat).
- Latencies:
  - Last ciphertext word accepted at cycle t → core_start at t+1.
  - core_done at cycle d → out_valid at d+1.
  - With out_ready held high: 4 output cycles, then LOAD.
- clear_err clears both sticky flags. If a new error event occurs in the same cycle as clear_err, the error wins (flag stays 1).
- Throughput: one block in flight; no overlap of input and output.

Decomposition:
- Shared package:
  - State enum: LOAD, START, WAIT, DRAIN.
  - WORDS_PER_BLOCK = 4, WORD_W = 32, BLOCK_W = 128.
- One natural sub-module: word_shift_reg (128-bit, 32-bit shift with load/clear), instantiated once for the input staging path and once for the output drain path.
- FSM and counters stay in the top module.

Test Plan:
- FIPS-197 vector:
  - Stimulus: key words 00010203, 04050607, 08090a0b, 0c0d0e0f, then ct words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a; core model returns the plaintext 12 cycles after start.
  - Required: core_key = 000102030405060708090a0b0c0d0e0f, one core_start pulse, out 00112233, 44556677, 8899aabb, ccddeeff with out_last on the 4th word.
- Backpressure:
  - Stimulus: out_ready toggled randomly.
  - Required: exactly 4 output beats in order, data stable while stalled, in_ready = 0 until the 4th beat completes.
- Key reuse:
  - Stimulus: one key load, then 3 ciphertext blocks back to back.
  - Required: 3 core_start pulses, core_key unchanged throughout, 12 output words.
- No key:
  - Stimulus: ct words after reset.
  - Required: no core_start, err_no_key = 1; clear_err → 0.
- Group type switch:
  - Stimulus: 2 key words, then 4 ct words with key_loaded = 1.
  - Required: key unchanged, block decrypted normally.
- Timeout and reset:
  - Stimulus: TIMEOUT_CYCLES = 20 and core_done never arrives.
  - Required: err_timeout at start+21, in_ready = 1, no out_valid.
  - Stimulus: reset asserted during DRAIN.
  - Required: out_valid = 0 and key_loaded = 0 immediately (asynchronous).
